// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings (funct3), empty ROB tag and divider FSM states
// shared by the multiply/divide unit and its divider.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Tag value meaning "no instruction" on the result bus.
  localparam int ZERO_ROB = 0;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative radix-2 restoring divider with start/busy/done/ack
// handshake. Optional macro MULDIV_FAST_DIV_EN lets divide-by-zero, signed
// overflow and |A| < |B| skip the shift-subtract loop.
//
// state     | meaning
// DIV_IDLE  | waiting for start
// DIV_BUSY  | one shift-subtract step per cycle, XLEN steps total
// DIV_DONE  | result held (sign-fixed) until ack
module muldiv_divider
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic [1:0]       i_op,      // funct3[1:0]: bit0 = unsigned, bit1 = remainder
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [ROB_W-1:0] i_tag,
  input  logic             i_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic [XLEN-1:0]  o_result,
  output logic [ROB_W-1:0] o_tag
);

  localparam int CW = $clog2(XLEN + 1);

  div_state_e        r_state, w_state_nxt;
  logic [XLEN-1:0]   r_quo, r_rem, r_dsr, r_a;
  logic [CW-1:0]     r_cnt;
  logic [ROB_W-1:0]  r_tag;
  logic              r_neg_q, r_neg_r, r_rem_sel, r_div0, r_ovf;

  logic              w_sgn, w_a_neg, w_b_neg, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_sub;
  logic              w_ge;
  logic [XLEN-1:0]   w_q_fix, w_r_fix;

  assign w_sgn   = !i_op[0];
  assign w_a_neg = w_sgn & i_a[XLEN-1];
  assign w_b_neg = w_sgn & i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;
  assign w_div0  = (i_b == '0);
  assign w_ovf   = w_sgn && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);

`ifdef MULDIV_FAST_DIV_EN
  assign w_fast = w_div0 | w_ovf | (w_a_mag < w_b_mag);
`else
  assign w_fast = 1'b0;
`endif

  // One restoring step: the partial remainder is always below the divisor, so
  // when the trial subtract succeeds the difference fits in XLEN bits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_sub   = w_shift[XLEN-1:0] - r_dsr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush always wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_state_nxt = w_fast ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (r_cnt == CW'(1)) w_state_nxt = DIV_DONE;
      DIV_DONE: if (i_ack) w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
    if (i_flush) w_state_nxt = DIV_IDLE;
  end

  // Operand latch on start, then shift-subtract iterations while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_dsr     <= '0;
      r_a       <= '0;
      r_cnt     <= '0;
      r_tag     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (i_start && r_state == DIV_IDLE) begin
      // A short-circuited divide leaves quotient 0 and remainder |A|.
      r_quo     <= w_fast ? '0 : w_a_mag;
      r_rem     <= w_fast ? w_a_mag : '0;
      r_dsr     <= w_b_mag;
      r_a       <= i_a;
      r_cnt     <= CW'(XLEN);
      r_tag     <= i_tag;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_rem_sel <= i_op[1];
      r_div0    <= w_div0;
      r_ovf     <= w_ovf;
    end else if (r_state == DIV_BUSY) begin
      r_quo <= {r_quo[XLEN-2:0], w_ge};
      r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sign fixup and the two architecturally defined special cases.
  always_comb begin
    w_q_fix = r_neg_q ? -r_quo : r_quo;
    w_r_fix = r_neg_r ? -r_rem : r_rem;
    if (r_div0) begin
      w_q_fix = '1;
      w_r_fix = r_a;
    end else if (r_ovf) begin
      w_q_fix = r_a;
      w_r_fix = '0;
    end
  end

  assign o_result = r_rem_sel ? w_r_fix : w_q_fix;
  assign o_tag    = r_tag;
  assign o_busy   = (r_state == DIV_BUSY);
  assign o_done   = (r_state == DIV_DONE);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M execution unit. Pipelined multiplier plus iterative
// divider sharing one result bus; multiplier output has priority. Optional
// macro MULDIV_FAST_DIV_EN (handled in muldiv_divider) shortens trivial divides.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [ROB_W-1:0] in_rob_tag,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  output logic             out_valid,
  output logic [XLEN-1:0]  out,
  output logic [ROB_W-1:0] out_rob_tag
);

  logic              w_is_div, w_acc, w_mul_acc, w_div_start;
  logic              w_div_busy, w_div_done, w_div_idle, w_div_ack;
  logic [XLEN-1:0]   w_div_res;
  logic [ROB_W-1:0]  w_div_tag;
  logic              w_a_sgn, w_b_sgn;
  logic [2*XLEN-1:0] w_a_x, w_b_x, w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_mul_vld;

  logic              r_vld [MUL_LAT];
  logic [XLEN-1:0]   r_res [MUL_LAT];
  logic [ROB_W-1:0]  r_tag [MUL_LAT];

  assign w_is_div    = in_op[2];
  assign w_div_idle  = !w_div_busy && !w_div_done;
  // Mul issue is held off while a div result waits, so the pipe drains for it.
  assign in_ready    = w_is_div ? w_div_idle : !w_div_done;
  assign w_acc       = in_valid && in_ready && !flush;
  assign w_mul_acc   = w_acc && !w_is_div;
  assign w_div_start = w_acc && w_is_div;

  // The XLEN+1-bit signed operands are extended to 2*XLEN bits; only the low
  // 2*XLEN product bits are ever returned, so a modular multiply is exact.
  assign w_a_sgn   = (in_op != OP_MULHU);
  assign w_b_sgn   = (in_op == OP_MUL) || (in_op == OP_MULH);
  assign w_a_x     = {{XLEN{w_a_sgn & A[XLEN-1]}}, A};
  assign w_b_x     = {{XLEN{w_b_sgn & B[XLEN-1]}}, B};
  assign w_prod    = w_a_x * w_b_x;
  assign w_mul_res = (in_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Multiplier pipeline: valid/tag/result shift every cycle, no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_res[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_mul_acc;
      r_res[0] <= w_mul_res;
      r_tag[0] <= in_rob_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      if (flush) begin
        for (int i = 0; i < MUL_LAT; i++) r_vld[i] <= 1'b0;
      end
    end
  end

  muldiv_divider #(
    .XLEN  (XLEN),
    .ROB_W (ROB_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (flush),
    .i_start  (w_div_start),
    .i_op     (in_op[1:0]),
    .i_a      (A),
    .i_b      (B),
    .i_tag    (in_rob_tag),
    .i_ack    (w_div_ack),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_result (w_div_res),
    .o_tag    (w_div_tag)
  );

  assign w_mul_vld = r_vld[MUL_LAT-1];
  assign w_div_ack = w_div_done && !w_mul_vld;

  // Result bus mux: multiplier first, then a finished divide, else empty.
  always_comb begin
    out_valid   = 1'b0;
    out         = '0;
    out_rob_tag = ROB_W'(ZERO_ROB);
    if (w_mul_vld) begin
      out_valid   = 1'b1;
      out         = r_res[MUL_LAT-1];
      out_rob_tag = r_tag[MUL_LAT-1];
    end else if (w_div_done) begin
      out_valid   = 1'b1;
      out         = w_div_res;
      out_rob_tag = w_div_tag;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed bench with an arithmetic reference
// model and a per-cycle result-bus schedule for muldiv_unit (XLEN=32, MUL_LAT=2).
module tb_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int ROB_W   = 4;
  localparam int MUL_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'd0;
  logic [ROB_W-1:0] in_rob_tag = '0;
  logic [XLEN-1:0]  A = '0;
  logic [XLEN-1:0]  B = '0;
  logic             out_valid;
  logic [XLEN-1:0]  out;
  logic [ROB_W-1:0] out_rob_tag;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rob_tag(in_rob_tag), .A(A), .B(B),
    .out_valid(out_valid), .out(out), .out_rob_tag(out_rob_tag)
  );

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [31:0] val;
  } mexp_t;

  mexp_t       mq[$];
  logic        d_pend = 1'b0;
  int          d_rdy = 0;
  logic [3:0]  d_tag = '0;
  logic [31:0] d_val = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          tcnt = 0;
  logic        fast_en;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    logic [31:0]     r;
    case (op[1:0])
      2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
      2'd1: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      2'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); r = p[63:32]; end
      default: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
      return op[1] ? r : q;
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic trivial_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    mb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
  endfunction

  task automatic next_tag(output logic [3:0] t);
    do begin
      tcnt = (tcnt % 15) + 1;
    end while (d_pend && tcnt == int'(d_tag));
    t = tcnt[3:0];
  endtask

  task automatic gen_ops(output logic [31:0] a, output logic [31:0] b);
    int k;
    k = $urandom_range(0, 7);
    a = $urandom;
    b = $urandom;
    case (k)
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 10) - 5; end
      3: b = $urandom_range(1, 300);
      default: ;
    endcase
  endtask

  // One clock cycle: drive inputs, check outputs/ready against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic run_cycle(input logic v, input logic [2:0] op, input logic [3:0] tg,
                           input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic        mul_now, d_done, rdy, acc, exp_v;
    logic [3:0]  exp_t;
    logic [31:0] exp_o;
    mexp_t       e;
    in_valid = v; in_op = op; in_rob_tag = tg; A = a; B = b; flush = fl;
    @(negedge clk);
    mul_now = (mq.size() > 0) && (mq[0].due == cyc);
    d_done  = d_pend && (d_rdy <= cyc);
    rdy     = op[2] ? !d_pend : !d_done;
    check("in_ready", {63'b0, in_ready}, {63'b0, rdy});
    exp_v = 1'b0; exp_t = '0; exp_o = '0;
    if (mul_now) begin
      exp_v = 1'b1; exp_t = mq[0].tag; exp_o = mq[0].val;
    end else if (d_done) begin
      exp_v = 1'b1; exp_t = d_tag; exp_o = d_val;
    end
    check("out_valid", {63'b0, out_valid}, {63'b0, exp_v});
    check("out_rob_tag", {60'b0, out_rob_tag}, {60'b0, exp_t});
    if (exp_v) check("out", {32'b0, out}, {32'b0, exp_o});
    acc = v && rdy && !fl;
    @(posedge clk);
    #1;
    if (mul_now) void'(mq.pop_front());
    else if (d_done) d_pend = 1'b0;
    if (fl) begin
      mq.delete();
      d_pend = 1'b0;
    end
    if (acc) begin
      if (op[2]) begin
        d_pend = 1'b1;
        d_tag  = tg;
        d_val  = ref_div(op, a, b);
        d_rdy  = cyc + ((fast_en && trivial_div(op, a, b)) ? 1 : XLEN + 1);
      end else begin
        e.due = cyc + MUL_LAT;
        e.tag = tg;
        e.val = ref_mul(op, a, b);
        mq.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  t;
    logic [2:0]  op;
`ifdef MULDIV_FAST_DIV_EN
    fast_en = 1'b1;
`else
    fast_en = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out", {32'b0, out}, 64'd0);
    check("rst_out_rob_tag", {60'b0, out_rob_tag}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the test plan.
    run_cycle(1'b1, 3'd1, 4'd5, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(3);
    run_cycle(1'b1, 3'd4, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(35);
    run_cycle(1'b1, 3'd6, 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(35);
    run_cycle(1'b1, 3'd5, 4'd6, 32'd9, 32'd0, 1'b0);
    idle(35);
    run_cycle(1'b1, 3'd6, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(35);

    // Divide finishes while back-to-back multiplies are in flight.
    run_cycle(1'b1, 3'd5, 4'd8, 32'd1000, 32'd7, 1'b0);
    idle(29);
    for (int i = 0; i < 8; i++) begin
      next_tag(t);
      run_cycle(1'b1, 3'(i % 4), t, $urandom, $urandom, 1'b0);
    end
    idle(5);

    // Flush while busy with both multiplier stages full, then a fresh divide.
    run_cycle(1'b1, 3'd4, 4'd9, 32'd12345, 32'd17, 1'b0);
    idle(4);
    run_cycle(1'b1, 3'd0, 4'd10, 32'd3, 32'd5, 1'b0);
    run_cycle(1'b1, 3'd3, 4'd11, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
    run_cycle(1'b1, 3'd2, 4'd12, 32'd77, 32'd88, 1'b1);
    run_cycle(1'b1, 3'd6, 4'd13, 32'hFFFF_FC00, 32'd7, 1'b0);
    idle(36);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      gen_ops(ra, rb);
      op = 3'($urandom_range(0, 7));
      next_tag(t);
      run_cycle(($urandom % 4) != 0, op, t, ra, rb, ($urandom % 40) == 0);
    end
    idle(40);

    // Asynchronous reset in the middle of a divide.
    run_cycle(1'b1, 3'd4, 4'd14, 32'd100000, 32'd3, 1'b0);
    idle(10);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out", {32'b0, out}, 64'd0);
    check("midrst_out_rob_tag", {60'b0, out_rob_tag}, 64'd0);
    mq.delete();
    d_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    in_op = 3'd4;
    #1;
    check("post_rst_div_ready", {63'b0, in_ready}, 64'd1);
    run_cycle(1'b0, 3'd4, 4'd0, 32'd0, 32'd0, 1'b0);
    run_cycle(1'b1, 3'd7, 4'd15, 32'd50, 32'd7, 1'b0);
    idle(36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised RV32M/RV64M execution unit that sits beside the integer ALU behind a reservation station. It executes MUL/MULH/MULHSU/MULHU through a pipelined multiplier and DIV/DIVU/REM/REMU through an iterative radix-2 divider. Results go out with their ROB tag on the common data bus to the RS, ROB and LS queue. Unlike the single-cycle ALU, it has multi-cycle latency, an issue handshake, result arbitration and flush.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- ROB_W, 4, ROB tag width; tag 0 means "no instruction"
- MUL_LAT, 2, multiplier pipeline depth in cycles (>=1)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  mispredict flush; kills all in-flight work
- in_valid  in  1  RS issues an op
- in_ready  out  1  unit can accept the presented op
- in_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rob_tag  in  ROB_W  destination ROB tag
- A, B  in  XLEN  rs1, rs2 values
- out_valid  out  1  result valid on CDB
- out  out  XLEN  result
- out_rob_tag  out  ROB_W  result tag; 0 whenever out_valid=0

## Operation
- Accept on in_valid & in_ready & !flush. in_op[2]=0 is a mul op; in_op[2]=1 is a div op.
- in_ready is combinational on in_op:
  - Mul op: ready when the divider state is not DONE.
  - Div op: ready only when the divider is IDLE.
- Multiplier:
  - Operands are sign/zero-extended to XLEN+1 bits per op, giving a signed 2(XLEN+1)-bit product.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return bits [2XLEN-1:XLEN].
  - Pipeline is MUL_LAT stages, each carrying a valid bit, tag and op. No stall.
- Divider FSM: IDLE -> BUSY -> DONE -> IDLE.
  - On accept: latch magnitudes, sign flags, op and tag. Counter = XLEN.
  - BUSY runs one restoring shift-subtract step per cycle, then moves to DONE when the counter reaches 0.
  - Sign fixup applies in DONE: quotient negated if signs differ; remainder takes the dividend's sign.
- RISC-V special cases (required results):
  - Divide by zero: quotient all-ones, remainder = A.
  - Signed overflow (A = most-negative, B = -1): quotient A, remainder 0.
- CDB arbitration:
  - Mul pipeline output has priority. DONE holds its result until a cycle with no mul output, then drives out and returns to IDLE.
  - No starvation: mul issue is blocked while DONE, so the pipeline drains within MUL_LAT cycles.
- Flush (synchronous): clears all mul stage valids and forces the divider to IDLE. An op presented in the flush cycle is dropped. out_valid is 0 from the next cycle.

## Timing
- Reset: out_valid=0, out=0, out_rob_tag=0, divider IDLE, all stage valids 0.
- in_ready is not a reset output: it is combinational on in_op and the divider state.
- Mul latency: accepted in cycle c, out_valid in cycle c+MUL_LAT.
- Div latency:
  - Accepted in cycle c: BUSY for cycles c+1..c+XLEN, DONE from c+XLEN+1.
  - Result appears in the first DONE cycle with no mul output.
  - IDLE the cycle after the result is driven; the next div can be accepted in that cycle.
- A mul may be accepted in the same cycle a div is accepted. Mul ops may issue every cycle while the divider is IDLE or BUSY.
- out/out_rob_tag are a combinational mux of registered sources. The mux introduces no extra cycle.
- Reset mid-operation: all state clears immediately. No partial result is ever emitted.

## Configuration
- MULDIV_FAST_DIV_EN defined:
  - Divide-by-zero and signed-overflow cases go IDLE -> DONE directly, with the result in cycle c+1 (subject to mul priority).
  - Divides where |A| < |B| also go direct: quotient 0, remainder A.
- Undefined: every div op takes the full XLEN BUSY cycles, with identical results.

## Structure
- Shared package/constants file: op encodings (MUL..REMU), ZERO_ROB tag constant, divider state encoding.
- One sub-module: muldiv_divider (FSM, counter, shift-subtract datapath, sign fixup). It has its own start/busy/done/ack handshake.
- The multiplier pipeline and CDB arbitration stay in muldiv_unit.

## Test plan
- XLEN=32, MUL_LAT=2. MULH A=0xFFFFFFFF, B=2, tag 5 -> out=0xFFFFFFFF, tag 5, exactly 2 cycles after accept.
- DIV A=-7, B=2, tag 3 -> out=0xFFFFFFFD, tag 3, in cycle c+33. REM of the same operands -> 0xFFFFFFFF.
- DIVU A=9, B=0 -> 0xFFFFFFFF. REM A=0x80000000, B=-1 -> 0. Both take 1 cycle with MULDIV_FAST_DIV_EN and 33 cycles without.
- Div reaches DONE while back-to-back MULs are in flight:
  - Mul results come out first; in_ready is low for mul while DONE.
  - The div result follows within MUL_LAT cycles.
  - No result or tag is lost.
- Flush during BUSY and with both mul stages valid -> out_valid=0 thereafter, no stale tag. A div accepted in the next cycle completes correctly.
- rst_n asserted mid-divide -> all outputs 0 immediately. After release, in_ready=1 for a div op.
